mac_pe_dbuf: RTL
================

# mac_pe_dbuf

Weight-stationary systolic-array processing element: multiply-accumulate with a two-stage pipeline, double-buffered (shadow/active) weights, signed/unsigned mode, optional saturation and a valid bit carried alongside the data. It replaces the single-cycle PE in the array tile. Weights can be preloaded into the shadow register and daisy-chained down a column while the active weight keeps computing. Partial sums flow vertically; ifmaps flow horizontally.

## Interface
- IFMAP_WIDTH, 16, ifmap operand width
- WEIGHT_WIDTH, 16, weight operand width
- OFMAP_WIDTH, 32, partial-sum width; must be >= IFMAP_WIDTH+WEIGHT_WIDTH
- SATURATE, 1, 1 = clamp on accumulate overflow, 0 = wrap
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- enable  in  1  pipeline advance; 0 = all compute/ifmap regs hold
- signed_mode  in  1  1 = two's-complement operands and sums, 0 = unsigned; static while valid data is in flight
- in_valid  in  1  ifmap_in/ofmap_in valid
- ifmap_in  in  IFMAP_WIDTH  activation from left neighbour
- ofmap_in  in  OFMAP_WIDTH  partial sum from upper neighbour
- weight_write_enable  in  1  load weight_in into shadow register
- weight_in  in  WEIGHT_WIDTH  weight from upper neighbour / loader
- weight_swap  in  1  copy shadow into active weight
- ifmap_out  out  IFMAP_WIDTH  registered ifmap to right neighbour
- ifmap_valid_out  out  1  registered in_valid to right neighbour
- weight_out  out  WEIGHT_WIDTH  shadow register contents, for daisy-chain loading
- ofmap_out  out  OFMAP_WIDTH  accumulated partial sum to lower neighbour
- out_valid  out  1  ofmap_out valid
- ovf_out  out  1  overflow occurred on this ofmap_out; qualified by out_valid

## Operation
- Reset: every register, including active and shadow weights, and every output go to 0.
- Stage 1, on an edge with enable=1: ifmap_out<=ifmap_in and ifmap_valid_out<=in_valid unconditionally. v1<=in_valid. If in_valid=1, prod_r<=ifmap_in*w_active (full IFMAP_WIDTH+WEIGHT_WIDTH bits, signed or unsigned per signed_mode) and psum_r<=ofmap_in. If in_valid=0, prod_r and psum_r hold.
- Stage 2, on an edge with enable=1: out_valid<=v1. If v1=1, then ofmap_out<=result and ovf_out<=overflow. If v1=0, ofmap_out holds and ovf_out<=0.
- Arithmetic: prod_r is sign-extended (signed) or zero-extended (unsigned) to OFMAP_WIDTH+1 bits and added to the extended psum_r.
  - Signed overflow: bit OFMAP_WIDTH differs from bit OFMAP_WIDTH-1. Unsigned overflow: carry out of bit OFMAP_WIDTH-1.
  - With SATURATE=1, an overflow clamps the result to the signed max/min (0x7FFF_FFFF / 0x8000_0000 at 32 bits) or to the unsigned max (0xFFFF_FFFF).
  - With SATURATE=0, the result is the low OFMAP_WIDTH bits. ovf_out reports the overflow in both modes.
- Weights are independent of enable:
  - weight_write_enable=1: shadow<=weight_in.
  - weight_swap=1: active<=shadow, using the pre-edge shadow value.
  - Both asserted on the same edge: active gets the old shadow, shadow gets the new weight_in.
- Stage 1 samples w_active. A multiply on the same edge as a swap uses the old active weight.

## Timing
- ofmap latency: 2 enabled edges from in_valid sampled to out_valid/ofmap_out. ifmap/ifmap_valid_out latency: 1 enabled edge. weight_out: 1 edge after weight_write_enable.
- A column of N PEs delivers weights via weight_out chaining in N write cycles, followed by one broadcast weight_swap.
- Stall: enable=0 freezes v1, prod_r, psum_r, ofmap_out, out_valid, ovf_out, ifmap_out and ifmap_valid_out. No data is lost or duplicated. Back-to-back valid inputs yield back-to-back outputs with throughput 1 per enabled cycle.
- Reset asserted mid-operation clears in-flight data immediately (asynchronous), so out_valid=0 at once. The first valid output after deassertion needs 2 enabled edges.

## Test plan
- Signed MAC: reset; write w=7; swap; ifmap=0xFFFD (-3), ofmap_in=100, in_valid=1 -> 2 edges later ofmap_out=79, out_valid=1, ovf_out=0. ifmap_out=0xFFFD after 1 edge.
- Saturation, SATURATE=1, signed: w=1, ifmap=0x0100, ofmap_in=0x7FFF_FFF0 -> ofmap_out=0x7FFF_FFFF, ovf_out=1. Unsigned, w=0xFFFF, ifmap=0xFFFF, ofmap_in=0xFFFF_FFFF -> ofmap_out=0xFFFF_FFFF, ovf_out=1.
- Wrap, SATURATE=0: same unsigned case -> ofmap_out=0xFFFE_0000, ovf_out=1.
- Double buffer: active w=2, write shadow=5, stream ifmap=10 with ofmap_in=0 each cycle, swap mid-stream.
  - Outputs are 20 up to and including the multiply on the swap edge, then 50.
  - Repeat with write and swap on the same edge -> active=old shadow, weight_out=new weight_in.
- Stall/bubbles: stream 3 valid inputs with enable dropped for 2 cycles between them and one in_valid=0 gap -> exactly 3 out_valid pulses, correct values, ofmap_out held during stall and bubble.
- Reset mid-stream: assert rst_n=0 between edges with valid data in both stages -> all outputs 0 immediately, weights 0. After release, a new input produces out_valid exactly 2 enabled edges later.

Source files
------------

// File: rtl/mac_pe_dbuf_if.sv
// mac_pe_dbuf_if: data, weight-load and result signals of one systolic PE
interface mac_pe_dbuf_if #(
  parameter int IFMAP_WIDTH  = 16,
  parameter int WEIGHT_WIDTH = 16,
  parameter int OFMAP_WIDTH  = 32
);
  logic                    i_enable;
  logic                    i_signed_mode;
  logic                    i_in_valid;
  logic [IFMAP_WIDTH-1:0]  i_ifmap_in;
  logic [OFMAP_WIDTH-1:0]  i_ofmap_in;
  logic                    i_weight_write_enable;
  logic [WEIGHT_WIDTH-1:0] i_weight_in;
  logic                    i_weight_swap;
  logic [IFMAP_WIDTH-1:0]  o_ifmap_out;
  logic                    o_ifmap_valid_out;
  logic [WEIGHT_WIDTH-1:0] o_weight_out;
  logic [OFMAP_WIDTH-1:0]  o_ofmap_out;
  logic                    o_out_valid;
  logic                    o_ovf_out;
  modport master (
    output i_enable, i_signed_mode, i_in_valid, i_ifmap_in, i_ofmap_in,
           i_weight_write_enable, i_weight_in, i_weight_swap,
    input  o_ifmap_out, o_ifmap_valid_out, o_weight_out, o_ofmap_out, o_out_valid, o_ovf_out
  );
  modport slave (
    input  i_enable, i_signed_mode, i_in_valid, i_ifmap_in, i_ofmap_in,
           i_weight_write_enable, i_weight_in, i_weight_swap,
    output o_ifmap_out, o_ifmap_valid_out, o_weight_out, o_ofmap_out, o_out_valid, o_ovf_out
  );
endinterface

// File: rtl/mac_pe_dbuf.sv
// mac_pe_dbuf: weight-stationary PE, 2-stage MAC pipeline with shadow/active weights
module mac_pe_dbuf #(
  parameter int IFMAP_WIDTH  = 16,
  parameter int WEIGHT_WIDTH = 16,
  parameter int OFMAP_WIDTH  = 32,
  parameter bit SATURATE     = 1'b1
) (
  input logic          clk,
  input logic          rst_n,
  mac_pe_dbuf_if.slave bus
);
  localparam int PW = IFMAP_WIDTH + WEIGHT_WIDTH;
  localparam int XW = OFMAP_WIDTH + 1;
  logic [WEIGHT_WIDTH-1:0] r_w_shadow, r_w_active;
  logic [IFMAP_WIDTH-1:0]  r_ifmap;
  logic                    r_ifmap_v, r_v1, r_out_v, r_ovf;
  logic [PW-1:0]           r_prod;
  logic [OFMAP_WIDTH-1:0]  r_psum, r_ofmap;
  logic                    w_sm;
  logic [PW-1:0]           w_a, w_b, w_prod;
  logic [XW-1:0]           w_sum;
  logic                    w_ovf;
  logic [OFMAP_WIDTH-1:0]  w_sat, w_result;
  // operands extended to full product width so one multiplier serves both modes
  always_comb begin
    w_sm     = bus.i_signed_mode;
    w_a      = {{WEIGHT_WIDTH{w_sm & bus.i_ifmap_in[IFMAP_WIDTH-1]}}, bus.i_ifmap_in};
    w_b      = {{IFMAP_WIDTH{w_sm & r_w_active[WEIGHT_WIDTH-1]}}, r_w_active};
    w_prod   = w_a * w_b;
    w_sum    = {{(XW-PW){w_sm & r_prod[PW-1]}}, r_prod} + {w_sm & r_psum[OFMAP_WIDTH-1], r_psum};
    w_ovf    = w_sm ? w_sum[XW-1] ^ w_sum[XW-2] : w_sum[XW-1];
    w_sat    = w_sm ? {w_sum[XW-1], {(OFMAP_WIDTH-1){~w_sum[XW-1]}}} : '1;
    w_result = (SATURATE && w_ovf) ? w_sat : w_sum[OFMAP_WIDTH-1:0];
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_w_shadow <= '0;
      r_w_active <= '0;
    end else begin
      if (bus.i_weight_write_enable) r_w_shadow <= bus.i_weight_in;
      if (bus.i_weight_swap) r_w_active <= r_w_shadow;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ifmap   <= '0;
      r_ifmap_v <= 1'b0;
      r_v1      <= 1'b0;
      r_prod    <= '0;
      r_psum    <= '0;
      r_out_v   <= 1'b0;
      r_ofmap   <= '0;
      r_ovf     <= 1'b0;
    end else if (bus.i_enable) begin
      r_ifmap   <= bus.i_ifmap_in;
      r_ifmap_v <= bus.i_in_valid;
      r_v1      <= bus.i_in_valid;
      if (bus.i_in_valid) begin
        r_prod <= w_prod;
        r_psum <= bus.i_ofmap_in;
      end
      r_out_v <= r_v1;
      r_ovf   <= r_v1 & w_ovf;
      if (r_v1) r_ofmap <= w_result;
    end
  end
  assign bus.o_ifmap_out       = r_ifmap;
  assign bus.o_ifmap_valid_out = r_ifmap_v;
  assign bus.o_weight_out      = r_w_shadow;
  assign bus.o_ofmap_out       = r_ofmap;
  assign bus.o_out_valid       = r_out_v;
  assign bus.o_ovf_out         = r_ovf;
endmodule
